ps2_command_parser: RTL and testbench
=====================================

// Module: ps2_command_parser
// PURPOSE
//  Sequential successor to the fixed-format PS/2 line interpreter. Takes a completed ASCII text line
//  from the keyboard line buffer and decodes "SET V <n>", "SET A <n>" and "FIRE".
//  Parses variable-length decimal fields one char/cycle, range-checks them, and drives the
//  velocity/angle/fire controls of the launcher core, with done/error status.
// PARAMETERS
//  LINE_CHARS  32   chars per input line; char 0 = input_line[8*LINE_CHARS-1 -: 8]
//  VAL_W       32   width of velocity/angle outputs
//  MAX_DIGITS  5    max decimal digits accepted in a SET field
//  V_DEFAULT   60   velocity reset value
//  A_DEFAULT   70   angle reset value
//  V_MAX       99999  largest legal velocity
//  A_MAX       90   largest legal angle
// PORTS
//  clock       in   1              system clock, all state on posedge
//  reset       in   1              asynchronous, active-high; clears all state
//  input_line  in   8*LINE_CHARS   ASCII line, left-justified, space/0x00 padded
//  line_ready  in   1              line valid; sampled only in IDLE
//  busy        out  1              high whenever state != IDLE
//  velocity    out  VAL_W          current velocity setting
//  angle       out  VAL_W          current angle setting
//  fire        out  1              one-cycle fire strobe
//  cmd_done    out  1              one-cycle strobe: command accepted and applied
//  cmd_error   out  1              one-cycle strobe: command rejected, no register changed
// BEHAVIOUR
//  Reset values: velocity=V_DEFAULT, angle=A_DEFAULT; fire, cmd_done, cmd_error, busy = 0; state IDLE.
//  Reset mid-parse: abandons the line and writes nothing.
//  FSM: IDLE -> DECODE -> DIGIT -> COMMIT -> IDLE. DECODE and DIGIT can also go to ERROR -> IDLE.
//  IDLE: line_ready=1 copies input_line into an internal line register -> DECODE.
//   line_ready while busy is ignored; the line is dropped and no flag is raised.
//  DECODE: chars 0..3=="FIRE" and char 4 is space/0x00/end -> fire=1 and cmd_done=1 next cycle -> IDLE.
//   chars 0..5=="SET V " or "SET A " -> latch target; acc=0, ndig=0, idx=6 -> DIGIT.
//   Anything else -> ERROR.
//  DIGIT: examines char[idx] each cycle.
//   '0'..'9' and ndig<MAX_DIGITS: acc=acc*10+digit, ndig++, idx++.
//   Space or 0x00, or idx==LINE_CHARS: ndig>=1 -> COMMIT, otherwise -> ERROR.
//   Any other char, or a digit when ndig==MAX_DIGITS -> ERROR.
//  Arithmetic: acc is VAL_W+4 bits wide so acc*10+digit cannot wrap. Leading zeros are legal.
//  COMMIT: compares acc with V_MAX or A_MAX (see CONFIGURATION), writes the target register,
//   pulses cmd_done -> IDLE. Trailing chars after the terminator are not checked.
//  ERROR: pulses cmd_error -> IDLE. velocity and angle keep their old values.
//  Strobes are registered and high for exactly one cycle; at most one of fire/cmd_error per line.
//  Latency, with cycle 0 = the capture edge:
//   FIRE: fire and cmd_done are high in cycle 2.
//   SET with k digits: the register updates and cmd_done is high in cycle k+4.
//   busy drops in the same cycle as the strobe, so the next line can be captured then.
// CONFIGURATION
//  RANGE_CLAMP_EN defined: a value above its max is clamped to V_MAX/A_MAX, written, and reported as
//   cmd_done.
//  RANGE_CLAMP_EN undefined: a value above its max goes to ERROR; nothing is written.
// STRUCTURE
//  Package ps2_cmd_pkg: ASCII constants (SPACE, NUL, '0', '9', 'S','E','T','V','A','F','I','R'),
//   FSM state encoding, target-select encoding.
//  Sub-module ps2_digit_accum: holds acc/ndig; inputs clr, en, ascii char; outputs acc, ndig,
//   is_digit, is_term.
//  The top level holds the FSM, line register, compare/clamp logic and output registers.
// TESTING
//  1 Reset: assert reset for 3 cycles mid-parse -> velocity=60, angle=70, all strobes 0, busy=0.
//  2 "SET V 00123" -> velocity=123 and cmd_done high in cycle 9; angle unchanged at 70.
//  3 "SET A 45" -> angle=45; then "SET A 120" -> clamp build: angle=90, cmd_done;
//    non-clamp build: cmd_error, angle stays 45.
//  4 "FIRE" -> fire=1 for exactly one cycle (cycle 2); "FIREX" -> cmd_error, fire stays 0.
//  5 Errors: "SET V 12a", "SET V " with no digits, "SET V 123456" (6 digits), "JUMP" ->
//    cmd_error once each, velocity unchanged.
//  6 Back-to-back: line_ready pulsed during busy -> that line is dropped; line_ready held high
//    -> the next command is captured in the cycle busy falls.

Source files
------------

// File: rtl/ps2_cmd_pkg.sv
// Shared definitions for the PS/2 command parser: ASCII codes, FSM states
// and the SET target selector.
package ps2_cmd_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NUL   = 8'h00;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_V     = 8'h56;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_I     = 8'h49;
    localparam logic [7:0] ASCII_R     = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_DIGIT,
        ST_COMMIT,
        ST_ERROR
    } state_t;

    typedef enum logic {
        TGT_VELOCITY,
        TGT_ANGLE
    } target_t;

endpackage

// File: rtl/ps2_digit_accum.sv
// Decimal field accumulator: classifies one ASCII char per cycle and folds
// digits into a value that is 4 bits wider than the result, so that
// acc*10+digit never wraps for any legal digit count.
module ps2_digit_accum
    import ps2_cmd_pkg::*;
#(
    parameter int VAL_W      = 32,
    parameter int MAX_DIGITS = 5
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               clr,
    input  logic                               en,
    input  logic [7:0]                         ascii,
    output logic [VAL_W+3:0]                   acc,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    ndig,
    output logic                               is_digit,
    output logic                               is_term
);

    localparam int ACC_W = VAL_W + 4;

    logic [7:0] digit;

    // Classify the current character and extract its digit value
    always_comb begin
        is_digit = (ascii >= ASCII_0) && (ascii <= ASCII_9);
        is_term  = (ascii == ASCII_SPACE) || (ascii == ASCII_NUL);
        digit    = ascii - ASCII_0;
    end

    // Accumulate one digit per enabled cycle; clr starts a new field
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            ndig <= '0;
        end else if (clr) begin
            acc  <= '0;
            ndig <= '0;
        end else if (en) begin
            acc  <= acc * ACC_W'(10) + ACC_W'(digit);
            ndig <= ndig + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_command_parser.sv
// PS/2 text command parser: decodes "SET V <n>", "SET A <n>" and "FIRE"
// from a captured line, one field character per cycle.
// Build option: define RANGE_CLAMP_EN to clamp out-of-range values to the
// maximum instead of rejecting the command.
module ps2_command_parser
    import ps2_cmd_pkg::*;
#(
    parameter int LINE_CHARS = 32,
    parameter int VAL_W      = 32,
    parameter int MAX_DIGITS = 5,
    parameter int V_DEFAULT  = 60,
    parameter int A_DEFAULT  = 70,
    parameter int V_MAX      = 99999,
    parameter int A_MAX      = 90
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [8*LINE_CHARS-1:0] input_line,
    input  logic                    line_ready,
    output logic                    busy,
    output logic [VAL_W-1:0]        velocity,
    output logic [VAL_W-1:0]        angle,
    output logic                    fire,
    output logic                    cmd_done,
    output logic                    cmd_error
);

    localparam int ACC_W  = VAL_W + 4;
    localparam int IDX_W  = $clog2(LINE_CHARS + 1);
    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
    localparam logic [NDIG_W-1:0] MAX_D     = NDIG_W'(MAX_DIGITS);
    localparam logic [ACC_W-1:0]  V_MAX_ACC = ACC_W'(V_MAX);
    localparam logic [ACC_W-1:0]  A_MAX_ACC = ACC_W'(A_MAX);

    state_t                  state;
    target_t                 target;
    logic [8*LINE_CHARS-1:0] line_q;
    logic [IDX_W-1:0]        idx;
    logic [7:0]              cur_char;
    logic                    acc_clr, acc_en;
    logic [ACC_W-1:0]        acc;
    logic [NDIG_W-1:0]       ndig;
    logic                    is_digit, is_term;
    logic                    is_fire, is_set_v, is_set_a;
    logic [ACC_W-1:0]        limit;
    logic                    commit_ok;
    logic [VAL_W-1:0]        commit_val;

    // Positions past the end of the line read as NUL, which terminates a field
    function automatic logic [7:0] char_at(input logic [8*LINE_CHARS-1:0] l, input int i);
        if (i >= LINE_CHARS) return ASCII_NUL;
        return l[8*(LINE_CHARS-i)-1 -: 8];
    endfunction

    assign busy = (state != ST_IDLE);

    // Keyword recognition on the captured line and digit-field control
    always_comb begin
        logic [7:0] c0, c1, c2, c3, c4, c5;
        logic       set_prefix;
        c0 = char_at(line_q, 0);
        c1 = char_at(line_q, 1);
        c2 = char_at(line_q, 2);
        c3 = char_at(line_q, 3);
        c4 = char_at(line_q, 4);
        c5 = char_at(line_q, 5);
        is_fire    = (c0 == ASCII_F) && (c1 == ASCII_I) && (c2 == ASCII_R) && (c3 == ASCII_E)
                     && ((c4 == ASCII_SPACE) || (c4 == ASCII_NUL));
        set_prefix = (c0 == ASCII_S) && (c1 == ASCII_E) && (c2 == ASCII_T)
                     && (c3 == ASCII_SPACE) && (c5 == ASCII_SPACE);
        is_set_v   = set_prefix && (c4 == ASCII_V);
        is_set_a   = set_prefix && (c4 == ASCII_A);
        cur_char   = char_at(line_q, int'(idx));
        acc_clr    = (state == ST_DECODE);
        acc_en     = (state == ST_DIGIT) && is_digit && (ndig < MAX_D);
    end

    // Range check against the selected target's maximum
    always_comb begin
        limit = (target == TGT_VELOCITY) ? V_MAX_ACC : A_MAX_ACC;
`ifdef RANGE_CLAMP_EN
        commit_ok  = 1'b1;
        commit_val = (acc > limit) ? limit[VAL_W-1:0] : acc[VAL_W-1:0];
`else
        commit_ok  = (acc <= limit);
        commit_val = acc[VAL_W-1:0];
`endif
    end

    ps2_digit_accum #(
        .VAL_W      (VAL_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_accum (
        .clock    (clock),
        .reset    (reset),
        .clr      (acc_clr),
        .en       (acc_en),
        .ascii    (cur_char),
        .acc      (acc),
        .ndig     (ndig),
        .is_digit (is_digit),
        .is_term  (is_term)
    );

    // Parser FSM with registered settings and one-cycle status strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            target    <= TGT_VELOCITY;
            line_q    <= '0;
            idx       <= '0;
            velocity  <= VAL_W'(V_DEFAULT);
            angle     <= VAL_W'(A_DEFAULT);
            fire      <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            fire      <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (line_ready) begin
                        line_q <= input_line;
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_fire) begin
                        fire     <= 1'b1;
                        cmd_done <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (is_set_v || is_set_a) begin
                        target <= is_set_v ? TGT_VELOCITY : TGT_ANGLE;
                        idx    <= IDX_W'(6);
                        state  <= ST_DIGIT;
                    end else begin
                        state <= ST_ERROR;
                    end
                end
                ST_DIGIT: begin
                    if (is_digit) begin
                        if (ndig == MAX_D) state <= ST_ERROR;
                        else               idx   <= idx + 1'b1;
                    end else if (is_term) begin
                        state <= (ndig != '0) ? ST_COMMIT : ST_ERROR;
                    end else begin
                        state <= ST_ERROR;
                    end
                end
                ST_COMMIT: begin
                    if (commit_ok) begin
                        if (target == TGT_VELOCITY) velocity <= commit_val;
                        else                        angle    <= commit_val;
                        cmd_done <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        state <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    cmd_error <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_parser.sv
// Directed bench for ps2_command_parser: table of command lines with expected
// strobe cycles and register values, plus hand-written reset and
// back-to-back sequences. Honours RANGE_CLAMP_EN the same way as the design.
module tb_ps2_command_parser;

    localparam int LC = 32;
    localparam int VW = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [8*LC-1:0] input_line = '0;
    logic            line_ready = 1'b0;
    logic            busy;
    logic [VW-1:0]   velocity, angle;
    logic            fire, cmd_done, cmd_error;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_command_parser dut (
        .clock      (clock),
        .reset      (reset),
        .input_line (input_line),
        .line_ready (line_ready),
        .busy       (busy),
        .velocity   (velocity),
        .angle      (angle),
        .fire       (fire),
        .cmd_done   (cmd_done),
        .cmd_error  (cmd_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        string cmd;
        int    done_cyc;  // 0 = no cmd_done expected
        int    nerr;
        int    fire_cyc;  // 0 = no fire expected
        int    vel;
        int    ang;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8*LC-1:0] mk_line(input string s);
        logic [8*LC-1:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < LC; i++) r[8*(LC-i)-1 -: 8] = s[i];
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string c, input int dc, input int ne, input int fc, input int v, input int a);
        vec_t t;
        t.cmd = c; t.done_cyc = dc; t.nerr = ne; t.fire_cyc = fc; t.vel = v; t.ang = a;
        vecs.push_back(t);
    endtask

    // Drive one line for a single capture cycle, then watch 16 cycles.
    // Cycle 0 is the capture cycle; cycle n is sampled n negedges later.
    task automatic apply_cmd(input string s, output int ndone, output int nerr, output int nfire,
                             output int done_cyc, output int fire_cyc);
        ndone = 0; nerr = 0; nfire = 0; done_cyc = 0; fire_cyc = 0;
        @(negedge clock);
        input_line = mk_line(s);
        line_ready = 1'b1;
        @(negedge clock);
        line_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (cmd_done) begin ndone++; if (done_cyc == 0) done_cyc = c; end
            if (fire)     begin nfire++; if (fire_cyc == 0) fire_cyc = c; end
            if (cmd_error) nerr++;
            if (c < 16) @(negedge clock);
        end
    endtask

    initial begin
        int nd, ne, nf, dc, fc, cnt, pat;
        string tag;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_velocity", int'(velocity), 60);
        check("reset_angle", int'(angle), 70);
        check("reset_busy", int'(busy), 0);
        check("reset_strobes", int'({fire, cmd_done, cmd_error}), 0);
        reset = 1'b0;

        add("SET V 00123",   9, 0, 0, 123,   70);
        add("SET A 45",      6, 0, 0, 123,   45);
`ifdef RANGE_CLAMP_EN
        add("SET A 120",     7, 0, 0, 123,   90);
        add("SET A 90",      6, 0, 0, 123,   90);
        add("SET A 91",      6, 0, 0, 123,   90);
`else
        add("SET A 120",     0, 1, 0, 123,   45);
        add("SET A 90",      6, 0, 0, 123,   90);
        add("SET A 91",      0, 1, 0, 123,   90);
`endif
        add("FIRE",          2, 0, 2, 123,   90);
        add("FIREX",         0, 1, 0, 123,   90);
        add("SET V 12a",     0, 1, 0, 123,   90);
        add("SET V ",        0, 1, 0, 123,   90);
        add("SET V 123456",  0, 1, 0, 123,   90);
        add("JUMP",          0, 1, 0, 123,   90);
        add("SET V 99999",   9, 0, 0, 99999, 90);
        add("SET V 7 junk",  5, 0, 0, 7,     90);
        add("SET A 0",       5, 0, 0, 7,     0);
        add("FIRE ",         2, 0, 2, 7,     0);

        foreach (vecs[i]) begin
            apply_cmd(vecs[i].cmd, nd, ne, nf, dc, fc);
            tag = $sformatf("[%0d]'%s'", i, vecs[i].cmd);
            check({tag, " done_count"}, nd, (vecs[i].done_cyc != 0) ? 1 : 0);
            check({tag, " done_cycle"}, dc, vecs[i].done_cyc);
            check({tag, " error_count"}, ne, vecs[i].nerr);
            check({tag, " fire_count"}, nf, (vecs[i].fire_cyc != 0) ? 1 : 0);
            check({tag, " fire_cycle"}, fc, vecs[i].fire_cyc);
            check({tag, " velocity"}, int'(velocity), vecs[i].vel);
            check({tag, " angle"}, int'(angle), vecs[i].ang);
        end

        // Reset in the middle of a parse restores defaults and drops the line
        @(negedge clock);
        input_line = mk_line("SET V 555");
        line_ready = 1'b1;
        @(negedge clock);
        line_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("midparse_busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("midparse_reset_velocity", int'(velocity), 60);
        check("midparse_reset_angle", int'(angle), 70);
        check("midparse_reset_busy", int'(busy), 0);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            cnt += int'(cmd_done) + int'(cmd_error) + int'(fire);
        end
        check("midparse_no_strobe_after", cnt, 0);
        check("midparse_velocity_after", int'(velocity), 60);

        // Line offered while busy is dropped
        @(negedge clock);
        input_line = mk_line("SET A 45");
        line_ready = 1'b1;
        @(negedge clock);
        line_ready = 1'b0;
        @(negedge clock);
        input_line = mk_line("SET A 12");
        line_ready = 1'b1;
        @(negedge clock);
        line_ready = 1'b0;
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            cnt += int'(cmd_done) + int'(cmd_error);
        end
        check("busy_drop_strobes", cnt, 1);
        check("busy_drop_angle", int'(angle), 45);

        // line_ready held high: next FIRE captured in the cycle busy falls,
        // giving a fire pulse every second cycle
        @(negedge clock);
        input_line = mk_line("FIRE");
        line_ready = 1'b1;
        pat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (fire) pat |= (1 << c);
        end
        line_ready = 1'b0;
        check("held_ready_fire_pattern", pat, 32'h554);
        repeat (4) @(negedge clock);
        check("held_ready_idle_after", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
